// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, load funct3 encodings
// and the writeback stage state encoding.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a raw memory word and extends it
// according to the load funct3; unknown encodings yield zero and flag illegal.
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic            illegal
);
  import cpu_pkg::*;

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Misaligned halfwords simply use addr_lo[1]; alignment traps live upstream.
  always_comb begin
    byte_val = rdata[{addr_lo, 3'b000} +: 8];
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wdata    = '0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:   wdata = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU:  wdata = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH:   wdata = {{(XLEN-16){half_val[15]}}, half_val};
      F3_LHU:  wdata = {{(XLEN-16){1'b0}}, half_val};
      F3_LW:   wdata = rdata;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data when
// needed, then writes the register file and bypass for one cycle.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_rd_we,
  input  logic              i_is_load,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_we,
  output logic [REG_AW-1:0] o_waddr,
  output logic [XLEN-1:0]   o_wdata,
  output logic              o_fwd_valid,
  output logic [REG_AW-1:0] o_fwd_rd,
  output logic [XLEN-1:0]   o_fwd_data,
  output logic              o_ld_busy,
  output logic [REG_AW-1:0] o_ld_rd,
  output logic [CNT_W-1:0]  o_instret,
  output logic              o_mem_err
);
  import cpu_pkg::*;

  wb_state_t         state;
  logic [REG_AW-1:0] held_rd;
  logic              held_rd_we;
  logic [2:0]        held_funct3;
  logic [1:0]        held_addr_lo;
  logic [XLEN-1:0]   held_wdata;
  logic [CNT_W-1:0]  instret;
  logic              mem_err;

  logic [XLEN-1:0]   align_wdata;
  logic              align_illegal;
  logic              accept;
  logic              in_commit;
  logic              commit_we;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (held_funct3),
    .addr_lo (held_addr_lo),
    .rdata   (i_mem_rdata),
    .wdata   (align_wdata),
    .illegal (align_illegal)
  );

  assign o_ready = (state != WAIT_MEM);
  assign accept  = i_valid && o_ready;

  // A response arriving outside WAIT_MEM has no owner, so it only raises the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      held_rd      <= '0;
      held_rd_we   <= 1'b0;
      held_funct3  <= '0;
      held_addr_lo <= '0;
      held_wdata   <= '0;
      instret      <= '0;
      mem_err      <= 1'b0;
    end else begin
      case (state)
        EMPTY, COMMIT: begin
          if (state == COMMIT) begin
            instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (i_mem_rvalid) begin
            mem_err <= 1'b1;
          end
          if (accept) begin
            held_rd    <= i_rd;
            held_rd_we <= i_rd_we;
            if (i_is_load) begin
              held_funct3  <= i_funct3;
              held_addr_lo <= i_addr_lo;
              state        <= WAIT_MEM;
            end else begin
              held_wdata <= i_alu_result;
              state      <= COMMIT;
            end
          end else begin
            state <= EMPTY;
          end
        end
        WAIT_MEM: begin
          if (i_mem_rvalid) begin
            held_wdata <= align_wdata;
            if (align_illegal) begin
              mem_err <= 1'b1;
            end
            state <= COMMIT;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign in_commit = (state == COMMIT);
  assign commit_we = in_commit && held_rd_we && (held_rd != '0);

  assign o_we        = commit_we;
  assign o_waddr     = in_commit ? held_rd : '0;
  assign o_wdata     = in_commit ? held_wdata : '0;
  assign o_fwd_valid = commit_we;
  assign o_fwd_rd    = in_commit ? held_rd : '0;
  assign o_fwd_data  = in_commit ? held_wdata : '0;
  assign o_ld_busy   = (state == WAIT_MEM);
  assign o_ld_rd     = (state == WAIT_MEM) ? held_rd : '0;
  assign o_instret   = instret;
  assign o_mem_err   = mem_err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: ALU writeback, load alignment, hazard
// outputs, retire counting, back-to-back throughput and reset/error handling.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd;
  logic        i_rd_we;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lo;
  logic [31:0] i_alu_result;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd;
  logic [31:0] o_fwd_data;
  logic        o_ld_busy;
  logic [4:0]  o_ld_rd;
  logic [63:0] o_instret;
  logic        o_mem_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_rd         (i_rd),
    .i_rd_we      (i_rd_we),
    .i_is_load    (i_is_load),
    .i_funct3     (i_funct3),
    .i_addr_lo    (i_addr_lo),
    .i_alu_result (i_alu_result),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_fwd_valid  (o_fwd_valid),
    .o_fwd_rd     (o_fwd_rd),
    .o_fwd_data   (o_fwd_data),
    .o_ld_busy    (o_ld_busy),
    .o_ld_rd      (o_ld_rd),
    .o_instret    (o_instret),
    .o_mem_err    (o_mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rd, input logic rd_we,
                               input logic is_load, input logic [2:0] f3,
                               input logic [1:0] alo, input logic [31:0] alu);
    i_valid      = valid;
    i_rd         = rd;
    i_rd_we      = rd_we;
    i_is_load    = is_load;
    i_funct3     = f3;
    i_addr_lo    = alo;
    i_alu_result = alu;
  endtask

  task automatic checkWrite(input string tag, input logic we, input logic [4:0] waddr,
                            input logic [31:0] wdata);
    checkOutput({tag, "_we"}, 64'(o_we), 64'(we));
    checkOutput({tag, "_fwd_valid"}, 64'(o_fwd_valid), 64'(we));
    if (we) begin
      checkOutput({tag, "_waddr"}, 64'(o_waddr), 64'(waddr));
      checkOutput({tag, "_wdata"}, 64'(o_wdata), 64'(wdata));
      checkOutput({tag, "_fwd_rd"}, 64'(o_fwd_rd), 64'(waddr));
      checkOutput({tag, "_fwd_data"}, 64'(o_fwd_data), 64'(wdata));
    end
  endtask

  // Load accepted, rvalid presented three cycles after the accept edge.
  task automatic doLoad(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] rdata,
                        input logic [31:0] expected);
    applyStimulus(1'b1, rd, 1'b1, 1'b1, f3, alo, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    checkOutput({tag, "_ready_wait"}, 64'(o_ready), 64'd0);
    checkOutput({tag, "_busy_wait"}, 64'(o_ld_busy), 64'd1);
    checkOutput({tag, "_ld_rd"}, 64'(o_ld_rd), 64'(rd));
    checkOutput({tag, "_we_wait"}, 64'(o_we), 64'd0);
    tick();
    tick();
    checkOutput({tag, "_busy_still"}, 64'(o_ld_busy), 64'd1);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rdata;
    tick();
    i_mem_rvalid = 1'b0;
    checkOutput({tag, "_busy_done"}, 64'(o_ld_busy), 64'd0);
    checkWrite(tag, 1'b1, rd, expected);
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready", 64'(o_ready), 64'd1);
    checkOutput("rst_instret", o_instret, 64'd0);
    checkOutput("rst_mem_err", 64'(o_mem_err), 64'd0);
    checkOutput("rst_busy", 64'(o_ld_busy), 64'd0);
    checkWrite("rst", 1'b0, 5'd0, 32'd0);

    // ALU op written the cycle after accept, counted the cycle after that.
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1234);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    checkWrite("add", 1'b1, 5'd5, 32'h0000_1234);
    tick();
    checkOutput("add_instret", o_instret, 64'd1);
    checkOutput("add_we_after", 64'(o_we), 64'd0);

    doLoad("lb",  5'd9,  3'b000, 2'd2, 32'h1280_3456, 32'hFFFF_FF80);
    doLoad("lhu", 5'd10, 3'b101, 2'd2, 32'h1280_3456, 32'h0000_1280);
    doLoad("lh",  5'd11, 3'b001, 2'd0, 32'h1280_3456, 32'h0000_3456);
    doLoad("lw",  5'd12, 3'b010, 2'd1, 32'h1280_3456, 32'h1280_3456);
    doLoad("lbu", 5'd13, 3'b100, 2'd3, 32'h1280_3456, 32'h0000_0012);
    checkOutput("legal_mem_err", 64'(o_mem_err), 64'd0);
    doLoad("ill", 5'd14, 3'b011, 2'd0, 32'h1280_3456, 32'h0000_0000);
    checkOutput("ill_mem_err", 64'(o_mem_err), 64'd1);
    checkOutput("loads_instret", o_instret, 64'd7);

    // Non-writing instructions still retire.
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0055);
    tick();
    checkWrite("rd0", 1'b0, 5'd0, 32'd0);
    checkOutput("rd0_ready", 64'(o_ready), 64'd1);
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0000_0066);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    checkWrite("nowe", 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("nowrite_instret", o_instret, 64'd9);

    // Three back-to-back ALU ops.
    applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_000A);
    tick();
    checkWrite("b2b_1", 1'b1, 5'd1, 32'h0000_000A);
    checkOutput("b2b_ready1", 64'(o_ready), 64'd1);
    applyStimulus(1'b1, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_000B);
    tick();
    checkWrite("b2b_2", 1'b1, 5'd2, 32'h0000_000B);
    checkOutput("b2b_ready2", 64'(o_ready), 64'd1);
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_000C);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    checkWrite("b2b_3", 1'b1, 5'd3, 32'h0000_000C);
    tick();
    checkOutput("b2b_instret", o_instret, 64'd12);
    checkOutput("b2b_idle_we", 64'(o_we), 64'd0);

    // Stray response while EMPTY is sticky until reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2_instret", o_instret, 64'd0);
    checkOutput("rst2_mem_err", 64'(o_mem_err), 64'd0);
    i_mem_rvalid = 1'b1;
    tick();
    i_mem_rvalid = 1'b0;
    checkOutput("stray_mem_err", 64'(o_mem_err), 64'd1);
    checkOutput("stray_we", 64'(o_we), 64'd0);
    tick();
    tick();
    checkOutput("stray_sticky", 64'(o_mem_err), 64'd1);

    // Reset while a load waits; rvalid during reset is ignored, a later one is stray.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 5'd20, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    checkOutput("rstwait_busy", 64'(o_ld_busy), 64'd1);
    rst          = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hCAFE_F00D;
    tick();
    rst          = 1'b0;
    i_mem_rvalid = 1'b0;
    checkOutput("rstwait_busy_clr", 64'(o_ld_busy), 64'd0);
    checkOutput("rstwait_ready", 64'(o_ready), 64'd1);
    checkOutput("rstwait_mem_err", 64'(o_mem_err), 64'd0);
    i_mem_rvalid = 1'b1;
    tick();
    i_mem_rvalid = 1'b0;
    checkWrite("rstwait_late", 1'b0, 5'd0, 32'd0);
    checkOutput("rstwait_late_err", 64'(o_mem_err), 64'd1);
    checkOutput("rstwait_instret", o_instret, 64'd0);

    // Reset arriving in COMMIT neither counts nor writes afterwards.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0777);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    checkWrite("rstcommit_pre", 1'b1, 5'd4, 32'h0000_0777);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkWrite("rstcommit_post", 1'b0, 5'd0, 32'd0);
    checkOutput("rstcommit_instret", o_instret, 64'd0);
    tick();
    checkOutput("rstcommit_instret2", o_instret, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the CPU pipeline, directly upstream of the register file.
- Takes one retiring instruction at a time from the memory stage: an ALU result, or a load whose data arrives later.
- Aligns and sign/zero-extends load data, then drives the register file write port (we / waddr / wdata).
- Also exports a bypass path, a load-pending hazard indication and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath and register width.
- REG_AW, 5, register address width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  memory stage presents an instruction.
- o_ready  out  1  stage can accept this cycle.
- i_rd  in  REG_AW  destination register.
- i_rd_we  in  1  instruction writes rd.
- i_is_load  in  1  result comes from the memory response.
- i_funct3  in  3  load type.
- i_addr_lo  in  2  low bits of the load address.
- i_alu_result  in  XLEN  result for non-loads.
- i_mem_rvalid  in  1  load data valid, single-cycle pulse.
- i_mem_rdata  in  XLEN  raw aligned word from data memory.
- o_we  out  1  register file write enable.
- o_waddr  out  REG_AW  register file write address.
- o_wdata  out  XLEN  register file write data.
- o_fwd_valid  out  1  bypass valid.
- o_fwd_rd  out  REG_AW  bypass register.
- o_fwd_data  out  XLEN  bypass data.
- o_ld_busy  out  1  a load is waiting for memory.
- o_ld_rd  out  REG_AW  destination of the waiting load.
- o_instret  out  CNT_W  retired-instruction count.
- o_mem_err  out  1  sticky error flag.

Behaviour:
- Reset:
  - State EMPTY; held entry cleared.
  - o_instret=0, o_mem_err=0.
  - All write, bypass and busy outputs 0; o_ready=1 from the first cycle after reset.
- State EMPTY:
  - o_ready=1.
  - Accept (i_valid && o_ready), non-load: capture rd, rd_we and wdata=i_alu_result; go to COMMIT.
  - Accept, load: capture rd, rd_we, funct3 and addr_lo; go to WAIT_MEM.
- State WAIT_MEM:
  - o_ready=0; o_ld_busy=1; o_ld_rd=held rd.
  - On i_mem_rvalid: wdata=align(i_mem_rdata); go to COMMIT.
  - Otherwise stay; the wait is unbounded.
- State COMMIT:
  - o_we = held rd_we && held rd!=0; o_waddr=held rd; o_wdata=held wdata.
  - o_fwd_* mirror o_we / o_waddr / o_wdata.
  - o_instret += 1 (wraps at 2^CNT_W), also when rd=0 or rd_we=0.
  - o_ready=1. Accept in this cycle follows the EMPTY transitions; with no accept, go to EMPTY.
- All outputs are driven from registered state only; there is no combinational path from i_* to o_we, o_wdata or o_fwd_*.
- Latency and throughput:
  - Non-load accepted at cycle N is written at N+1; throughput 1/cycle.
  - Load accepted at N with rvalid at M>N is written at M+1.
  - rvalid in the same cycle as the load's accept is not consumed; memory must respond at N+1 or later.
- Load alignment:
  - 000 LB: sign-extend byte addr_lo.
  - 100 LBU: zero-extend byte addr_lo.
  - 001 LH: sign-extend halfword addr_lo[1].
  - 101 LHU: zero-extend halfword addr_lo[1].
  - 010 LW: full word; addr_lo ignored.
  - 011/110/111: wdata=0, o_mem_err set.
  - Misaligned halfwords use addr_lo[1] only; traps are handled upstream.
- o_mem_err:
  - Also set by i_mem_rvalid in EMPTY or COMMIT.
  - Cleared only by rst.
- Reset mid-operation:
  - A load in WAIT_MEM is discarded with no write.
  - rvalid during the reset cycle is ignored; a later stray rvalid sets o_mem_err.
  - COMMIT under rst: no write, no count.

Decomposition:
- cpu_pkg:
  - XLEN and REG_AW constants.
  - Load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_t enum {EMPTY, WAIT_MEM, COMMIT}.
- Sub-module load_align: purely combinational (funct3, addr_lo, rdata -> wdata, illegal), instantiated once.

Test Plan:
- rst, then ADD i_alu_result=0x0000_1234, i_rd=5 accepted at cycle 1 -> cycle 2: o_we=1, o_waddr=5, o_wdata=0x1234, o_fwd_valid=1; cycle 3: o_instret=1, o_we=0.
- LB, addr_lo=2, rdata=0x1280_3456, rvalid 3 cycles after accept -> o_ready=0, o_ld_busy=1, o_ld_rd=rd while waiting; write 0xFFFF_FF80 the cycle after rvalid.
- Same rdata with LHU addr_lo=2 -> 0x0000_1280; LH addr_lo=0 -> 0x0000_3456; LW -> 0x1280_3456; LBU addr_lo=3 -> 0x0000_0012; funct3=011 -> wdata=0, o_mem_err=1.
- rd=0 with rd_we=1, and rd=7 with rd_we=0 -> o_we=0, o_fwd_valid=0; o_instret increments by 2.
- Three back-to-back ALU ops (rd=1,2,3; data 0xA,0xB,0xC) -> o_ready stays 1; writes on three consecutive cycles in order.
- rvalid while EMPTY -> o_mem_err=1, held until rst. Reset asserted during WAIT_MEM then rvalid after reset -> no write, o_mem_err=1, o_instret unchanged.
